// File: rtl/accel_pkg.sv
// Shared constants, state encodings and the per-axis tilt decode for accel_tilt_reader.
package accel_pkg;
  localparam logic [7:0] CMD_WRITE     = 8'h0A;
  localparam logic [7:0] CMD_READ      = 8'h0B;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_XDATA     = 8'h08;
  localparam logic [7:0] MEASURE_MODE  = 8'h02;

  typedef enum logic [1:0] {S_CFG, S_IDLE, S_READ, S_UPDATE} state_e;
  typedef enum logic [1:0] {P_GAP, P_BYTE, P_HOLD} phase_e;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic [7:0] thr;
  } tilt_t;

  // Negation is taken in 9 bits so -128 saturates cleanly to 127.
  function automatic tilt_t tilt_decode(input logic [7:0] s, input logic [7:0] dz);
    logic signed [8:0] sv;
    logic signed [8:0] neg;
    logic signed [8:0] dzs;
    tilt_t t;
    sv  = signed'({s[7], s});
    neg = -sv;
    dzs = signed'({1'b0, dz});
    t   = '0;
    if (sv > dzs) begin
      t.inc = 1'b1;
      t.thr = s;
    end else if (sv < -dzs) begin
      t.dec = 1'b1;
      t.thr = (neg > 9'sd127) ? 8'd127 : neg[7:0];
    end
    return t;
  endfunction
endpackage

// File: rtl/accel_tilt_reader_spi_byte_xfer.sv
// One full-duplex SPI mode-0 byte, MSB first; owns SCLK and MOSI, CS belongs to the parent.
module spi_byte_xfer #(
  parameter int HP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       spi_miso,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       spi_sclk,
  output logic       spi_mosi
);
  logic        active_q, active_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [3:0]  ecnt_q, ecnt_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;

  always_comb begin
    active_d = active_q;
    hcnt_d   = hcnt_q;
    ecnt_d   = ecnt_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = 1'b0;
    if (!active_q) begin
      if (start) begin
        active_d = 1'b1;
        hcnt_d   = '0;
        ecnt_d   = '0;
        mosi_d   = tx_byte[7];
        tx_d     = {tx_byte[6:0], 1'b0};
      end
    end else if (hcnt_q == 16'(HP - 1)) begin
      hcnt_d = '0;
      ecnt_d = ecnt_q + 4'd1;
      if (!ecnt_q[0]) begin
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], spi_miso};
      end else begin
        sclk_d = 1'b0;
        if (ecnt_q == 4'd15) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          mosi_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
    end else begin
      hcnt_d = hcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      hcnt_q   <= hcnt_d;
      ecnt_q   <= ecnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
    end
  end

  assign done     = done_q;
  assign rx_byte  = rx_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
endmodule

// File: rtl/accel_tilt_reader.sv
// ADXL362 tilt reader: configures measure mode, polls X/Y, decodes to direction flags + magnitude.
// Optional TILT_AVG_EN averages four consecutive reads per axis before decoding.
module accel_tilt_reader
  import accel_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ    = 100000000,
  parameter int SCLK_HZ             = 1000000,
  parameter int SAMPLE_HZ           = 100,
  parameter int DEAD_ZONE           = 16,
  parameter int SIMULATE            = 0,
  parameter int SIMULATE_SAMPLE_CNT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_miso,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       x_increment,
  output logic       x_decrement,
  output logic       y_increment,
  output logic       y_decrement,
  output logic [7:0] x_threshold,
  output logic [7:0] y_threshold,
  output logic       sample_valid,
  output logic       init_done
);
  localparam int HP_RAW     = CLK_FREQUENCY_HZ / (2 * SCLK_HZ);
  localparam int HP         = (SIMULATE != 0) ? 2 : ((HP_RAW < 2) ? 2 : HP_RAW);
  localparam int SAMPLE_CNT = (SIMULATE != 0) ? SIMULATE_SAMPLE_CNT : CLK_FREQUENCY_HZ / SAMPLE_HZ;
  localparam logic [7:0] DZ = 8'(DEAD_ZONE);

  state_e      state_q, state_d;
  phase_e      ph_q, ph_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [1:0]  idx_q, idx_d, sel, last_idx;
  logic        cs_n_q, cs_n_d, init_done_q, init_done_d, pending_q, pending_d;
  logic        sample_valid_q, sample_valid_d, tick, start;
  logic [31:0] samp_cnt_q, samp_cnt_d;
  logic [7:0]  x_raw_q, x_raw_d, y_raw_q, y_raw_d, tx_byte, rx_byte;
  logic        xfer_done;
  tilt_t       x_q, x_d, y_q, y_d;
`ifdef TILT_AVG_EN
  logic signed [9:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d, sum_x, sum_y, avg_x, avg_y;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
`endif

  spi_byte_xfer #(.HP(HP)) u_xfer (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tx_byte (tx_byte),
    .spi_miso(spi_miso),
    .done    (xfer_done),
    .rx_byte (rx_byte),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi)
  );

  assign sel      = (ph_q == P_BYTE) ? idx_q + 2'd1 : 2'd0;
  assign last_idx = (state_q == S_CFG) ? 2'd2 : 2'd3;

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == S_CFG) begin
      case (sel)
        2'd0:    tx_byte = CMD_WRITE;
        2'd1:    tx_byte = REG_POWER_CTL;
        2'd2:    tx_byte = MEASURE_MODE;
        default: tx_byte = 8'h00;
      endcase
    end else begin
      case (sel)
        2'd0:    tx_byte = CMD_READ;
        2'd1:    tx_byte = REG_XDATA;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    wcnt_d         = wcnt_q;
    idx_d          = idx_q;
    cs_n_d         = cs_n_q;
    init_done_d    = init_done_q;
    pending_d      = pending_q;
    samp_cnt_d     = samp_cnt_q;
    x_raw_d        = x_raw_q;
    y_raw_d        = y_raw_q;
    x_d            = x_q;
    y_d            = y_q;
    sample_valid_d = 1'b0;
    start          = 1'b0;
    tick           = 1'b0;
`ifdef TILT_AVG_EN
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    rd_cnt_d = rd_cnt_q;
    sum_x    = acc_x_q + {{2{x_raw_q[7]}}, x_raw_q};
    sum_y    = acc_y_q + {{2{y_raw_q[7]}}, y_raw_q};
    avg_x    = sum_x >>> 2;
    avg_y    = sum_y >>> 2;
`endif
    if (init_done_q) begin
      if (samp_cnt_q == 32'(SAMPLE_CNT - 1)) begin
        samp_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        samp_cnt_d = samp_cnt_q + 32'd1;
      end
    end
    if (state_q == S_IDLE && pending_q) begin
      pending_d = 1'b0;
      state_d   = S_READ;
    end
    if (tick) pending_d = 1'b1;

    case (state_q)
      S_CFG, S_READ: begin
        case (ph_q)
          P_GAP: begin
            // CS falls on the same edge the first byte loads, giving exactly HP of setup.
            if (wcnt_q == 16'(2 * HP - 1)) begin
              wcnt_d = '0;
              cs_n_d = 1'b0;
              ph_d   = P_BYTE;
              idx_d  = '0;
              start  = 1'b1;
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end
          P_BYTE: begin
            if (xfer_done) begin
              idx_d = idx_q + 2'd1;
              if (state_q == S_READ && idx_q == 2'd2) x_raw_d = rx_byte;
              if (state_q == S_READ && idx_q == 2'd3) y_raw_d = rx_byte;
              if (idx_q == last_idx) begin
                ph_d   = P_HOLD;
                wcnt_d = '0;
              end else begin
                start = 1'b1;
              end
            end
          end
          default: begin
            if (wcnt_q == 16'(HP - 2)) begin
              cs_n_d = 1'b1;
              ph_d   = P_GAP;
              wcnt_d = '0;
              if (state_q == S_CFG) begin
                init_done_d = 1'b1;
                state_d     = S_IDLE;
              end else begin
                state_d = S_UPDATE;
              end
            end else begin
              wcnt_d = wcnt_q + 16'd1;
            end
          end
        endcase
      end
      S_UPDATE: begin
        state_d = S_IDLE;
`ifdef TILT_AVG_EN
        rd_cnt_d = rd_cnt_q + 2'd1;
        if (rd_cnt_q == 2'd3) begin
          x_d            = tilt_decode(avg_x[7:0], DZ);
          y_d            = tilt_decode(avg_y[7:0], DZ);
          acc_x_d        = '0;
          acc_y_d        = '0;
          sample_valid_d = 1'b1;
        end else begin
          acc_x_d = sum_x;
          acc_y_d = sum_y;
        end
`else
        x_d            = tilt_decode(x_raw_q, DZ);
        y_d            = tilt_decode(y_raw_q, DZ);
        sample_valid_d = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_CFG;
      ph_q           <= P_GAP;
      wcnt_q         <= '0;
      idx_q          <= '0;
      cs_n_q         <= 1'b1;
      init_done_q    <= 1'b0;
      pending_q      <= 1'b0;
      samp_cnt_q     <= '0;
      x_raw_q        <= '0;
      y_raw_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      wcnt_q         <= wcnt_d;
      idx_q          <= idx_d;
      cs_n_q         <= cs_n_d;
      init_done_q    <= init_done_d;
      pending_q      <= pending_d;
      samp_cnt_q     <= samp_cnt_d;
      x_raw_q        <= x_raw_d;
      y_raw_q        <= y_raw_d;
      x_q            <= x_d;
      y_q            <= y_d;
      sample_valid_q <= sample_valid_d;
    end
  end

`ifdef TILT_AVG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      rd_cnt_q <= '0;
    end else begin
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`endif

  assign spi_cs_n     = cs_n_q;
  assign x_increment  = x_q.inc;
  assign x_decrement  = x_q.dec;
  assign x_threshold  = x_q.thr;
  assign y_increment  = y_q.inc;
  assign y_decrement  = y_q.dec;
  assign y_threshold  = y_q.thr;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
endmodule
